// File: rtl/multicycle_adder.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per clock with a registered carry,
// and uses a START/BUSY/DONE handshake so the control FSM can stall on it.
module multicycle_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SUB,
   input  logic             CIN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT,
   output logic             OVF,
   output logic             BUSY,
   output logic             DONE
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   generate
      if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_paramCheck
         $error("multicycle_adder: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
      end
   endgenerate

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_part;
   logic             r_carry;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [31:0]      w_base;
   logic [CHUNK-1:0] w_aChunk;
   logic [CHUNK-1:0] w_bChunk;
   logic [CHUNK:0]   w_chunkFull;
   logic [CHUNK-1:0] w_chunkSum;
   logic             w_chunkCarry;
   logic [WIDTH-1:0] w_nextPart;
   logic             w_msbCarryIn;
   logic             w_lastChunk;

   assign w_base       = 32'(r_idx) * 32'(CHUNK);
   assign w_aChunk     = r_a[w_base +: CHUNK];
   assign w_bChunk     = r_b[w_base +: CHUNK];
   assign w_chunkFull  = {1'b0, w_aChunk} + {1'b0, w_bChunk} + (CHUNK+1)'(r_carry);
   assign w_chunkSum   = w_chunkFull[CHUNK-1:0];
   assign w_chunkCarry = w_chunkFull[CHUNK];
   assign w_lastChunk  = (r_idx == LAST_IDX);

   // Recover the carry into the MSB from the MSB sum bit; only meaningful on the last chunk.
   assign w_msbCarryIn = w_chunkSum[CHUNK-1] ^ r_a[WIDTH-1] ^ r_b[WIDTH-1];

   always_comb begin
      w_nextPart = r_part;
      w_nextPart[w_base +: CHUNK] = w_chunkSum;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_part  <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_FIN: begin
               if (START) begin
                  r_a     <= A;
                  r_b     <= B ^ {WIDTH{SUB}};
                  r_carry <= SUB ? 1'b1 : CIN;
                  r_idx   <= '0;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_part  <= w_nextPart;
               r_carry <= w_chunkCarry;
               r_idx   <= r_idx + 1'b1;
               if (w_lastChunk) begin
                  r_sum   <= w_nextPart;
                  r_cout  <= w_chunkCarry;
                  r_ovf   <= w_msbCarryIn ^ w_chunkCarry;
                  r_state <= S_FIN;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign SUM  = r_sum;
   assign COUT = r_cout;
   assign OVF  = r_ovf;
   assign BUSY = (r_state == S_RUN);
   assign DONE = (r_state == S_FIN);

endmodule

// File: doc/multicycle_adder.md
Name: multicycle_adder

Overview:
- Parametrised, sequential successor to the gate-level half adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, using a registered carry between chunks.
- Serves as the low-area arithmetic unit for the RISC datapath.
- Uses a START/BUSY/DONE handshake so the control FSM can stall while it runs.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH % CHUNK must be 0 and CHUNK >= 1; elaboration error otherwise.
- NCHUNK is derived as WIDTH/CHUNK. It is the number of RUN cycles.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request a new operation; sampled on CLK rising edge.
- SUB  input  1  0 = A+B+CIN, 1 = A-B (A + ~B + 1).
- CIN  input  1  carry in; ignored when SUB=1.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- SUM  output  WIDTH  registered result.
- COUT  output  1  carry out of MSB. For SUB=1, 1 means no borrow.
- OVF  output  1  two's-complement signed overflow.
- BUSY  output  1  high while computing.
- DONE  output  1  one-cycle pulse when SUM/COUT/OVF are updated.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset (RST=1 at an edge): state=IDLE; SUM=0, COUT=0, OVF=0, BUSY=0, DONE=0; internal operand/partial registers cleared. RST overrides START.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - START=1 at edge k latches A, B^{WIDTH{SUB}}, and carry = SUB ? 1 : CIN.
  - Chunk index = 0; go to RUN; BUSY=1 from edge k.
- RUN:
  - At each edge, chunk i (bits i*CHUNK .. i*CHUNK+CHUNK-1) = A_chunk + B_chunk + carry.
  - The result is written into the internal partial register and carry is updated; i increments.
  - At the edge completing chunk NCHUNK-1 (edge k+NCHUNK), go to FIN.
  - At that same edge, load SUM from the partial register, COUT = final carry, OVF = carry into MSB XOR carry out of MSB.
  - BUSY=0 and DONE=1 from that edge.
- FIN:
  - DONE=1 for exactly this one cycle; next edge returns to IDLE with DONE=0.
  - START=1 sampled in FIN is accepted exactly as in IDLE (back-to-back). The next state is RUN and DONE drops.
- Latency: DONE is high in the cycle after edge k+NCHUNK. Throughput is one operation per NCHUNK+1 cycles.
- START while BUSY=1 is ignored (not queued). A/B/SUB/CIN changes during RUN have no effect.
- SUM/COUT/OVF hold their last values during RUN and IDLE. They change only on FIN entry or reset.
- Reset mid-RUN aborts the operation: no DONE, and outputs are zeroed.
- Arithmetic is modulo 2^WIDTH; no saturation.
- CHUNK=WIDTH degenerates to a 1-cycle RUN, still with FIN/DONE.

Test Plan (WIDTH=32, CHUNK=8 unless noted):
- Reset, then idle 5 cycles -> SUM=0, COUT=0, OVF=0, BUSY=0, DONE=0 throughout.
- START, SUB=0, CIN=0, A=0x000000FF, B=0x00000001 -> BUSY high 4 cycles, then DONE pulse 1 cycle with SUM=0x00000100, COUT=0, OVF=0. This checks carry propagation across the chunk boundary.
- ADD with A=0x7FFFFFFF, B=1, then A=0xFFFFFFFF, B=1, CIN=1:
  - first -> SUM=0x80000000, OVF=1, COUT=0;
  - second -> SUM=0x00000001, COUT=1, OVF=0.
- SUB=1, CIN=1 (ignored), A=5, B=7 -> SUM=0xFFFFFFFE, COUT=0, OVF=0. Then A=0x80000000, B=1 -> SUM=0x7FFFFFFF, COUT=1, OVF=1.
- START held high continuously with changing operands -> ops accepted only in IDLE/FIN; one DONE every 5 cycles. Operand changes during RUN do not alter results.
- Assert RST in 2nd RUN cycle -> no DONE, all outputs 0, next START completes normally. Repeat with CHUNK=32 and CHUNK=1 -> DONE latency of 1 and 32 cycles respectively.
